// File: rtl/det_pkg.sv
// rtl/det_pkg.sv - shared widths, element count and FSM encoding for the determinant loader
//
// Contents:
//   ELEM_W_DEF / RES_W_DEF  default signed element and determinant widths
//   N_ELEM / IDX_W          matrix element count (4x4) and write-index width
//   TIMEOUT_CYC_DEF         default WAIT-state abort threshold (used with DET_TIMEOUT_EN)
//   S_* / state_t           loader FSM state encoding
package det_pkg;

  localparam int ELEM_W_DEF      = 8;
  localparam int RES_W_DEF       = 16;
  localparam int N_ELEM          = 16;
  localparam int IDX_W           = $clog2(N_ELEM);
  localparam int TIMEOUT_CYC_DEF = 256;

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    ST_LOAD  = S_LOAD,
    ST_START = S_START,
    ST_WAIT  = S_WAIT,
    ST_HOLD  = S_HOLD
  } state_t;

endpackage

// File: rtl/mat_regbuf_4x4.sv
// rtl/mat_regbuf_4x4.sv - 16-entry write-indexed element register bank with flat output
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (clears all entries)
//   we           write enable for one entry this cycle
//   widx         entry index to write, 0 = element a
//   wdata        element value
//   mat_flat     all entries, entry k at [k*ELEM_W +: ELEM_W]
module mat_regbuf_4x4
  import det_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [IDX_W-1:0]         widx,
  input  logic [ELEM_W-1:0]        wdata,
  output logic [N_ELEM*ELEM_W-1:0] mat_flat
);

  logic [ELEM_W-1:0] elem [N_ELEM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_ELEM; k++) begin
        elem[k] <= '0;
      end
    end else if (we) begin
      elem[widx] <= wdata;
    end
  end

  for (genvar g = 0; g < N_ELEM; g++) begin : g_flat
    assign mat_flat[g*ELEM_W +: ELEM_W] = elem[g];
  end

endmodule

// File: rtl/det_matrix_loader.sv
// rtl/det_matrix_loader.sv - buffers a row-major 4x4 matrix, runs the determinant unit, holds the result
//
// Optional feature macro: DET_TIMEOUT_EN (WAIT-state timeout with sticky err).
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   flush        synchronous abort: back to LOAD, partial matrix and pending result dropped
//   in_valid     element available      in_ready   loader accepts element (LOAD only)
//   in_data      signed element, row-major a..p
//   mat_flat     buffered matrix, element k at [k*ELEM_W +: ELEM_W]
//   det_start    one-cycle start pulse  det_done   completion (may stay high)
//   det_result   determinant, sampled on the det_done rising edge
//   res_valid    result held            res_ready  host takes result
//   res_data     captured determinant
//   busy         high in START/WAIT     err        sticky timeout flag (0 without DET_TIMEOUT_EN)
module det_matrix_loader
  import det_pkg::*;
#(
  parameter int ELEM_W      = ELEM_W_DEF,
  parameter int RES_W       = RES_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ELEM_W-1:0]        in_data,
  output logic [N_ELEM*ELEM_W-1:0] mat_flat,
  output logic                     det_start,
  input  logic                     det_done,
  input  logic [RES_W-1:0]         det_result,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RES_W-1:0]         res_data,
  output logic                     busy,
  output logic                     err
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             det_done_q;
  logic             done_rise;
  logic             wr_en;

  // det_done_q follows det_done in every state, so a level left high by an
  // earlier operation never looks like a fresh edge when WAIT is entered.
  assign done_rise = det_done & ~det_done_q;

  // in_ready is registered and is high exactly in LOAD; flush wins over a
  // same-cycle element.
  assign wr_en = in_ready & in_valid & ~flush;

`ifdef DET_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             timeout_hit;

  // wait_cnt is 0 in the first WAIT cycle, so the abort fires at the end of
  // the TIMEOUT_CYC-th WAIT cycle.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign err         = err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign err = 1'b0;
`endif

  mat_regbuf_4x4 #(
    .ELEM_W (ELEM_W)
  ) u_regbuf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_en),
    .widx     (idx),
    .wdata    (in_data),
    .mat_flat (mat_flat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_done_q <= 1'b0;
    end else begin
      det_done_q <= det_done;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      idx       <= '0;
      in_ready  <= 1'b1;
      det_start <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
`ifdef DET_TIMEOUT_EN
      wait_cnt  <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      det_start <= 1'b0;
      if (flush) begin
        state     <= ST_LOAD;
        idx       <= '0;
        in_ready  <= 1'b1;
        busy      <= 1'b0;
        res_valid <= 1'b0;
`ifdef DET_TIMEOUT_EN
        err_q     <= 1'b0;
`endif
      end else begin
        unique case (state)
          ST_LOAD: begin
            if (wr_en) begin
              idx <= idx + IDX_W'(1);
              if (idx == IDX_W'(N_ELEM - 1)) begin
                state     <= ST_START;
                det_start <= 1'b1;
                in_ready  <= 1'b0;
                busy      <= 1'b1;
              end
            end
          end
          ST_START: begin
            state <= ST_WAIT;
`ifdef DET_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
          ST_WAIT: begin
            if (done_rise) begin
              res_data  <= det_result;
              res_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_HOLD;
`ifdef DET_TIMEOUT_EN
            end else if (timeout_hit) begin
              err_q    <= 1'b1;
              busy     <= 1'b0;
              in_ready <= 1'b1;
              idx      <= '0;
              state    <= ST_LOAD;
            end else begin
              wait_cnt <= wait_cnt + CNT_W'(1);
`endif
            end
          end
          ST_HOLD: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              in_ready  <= 1'b1;
              idx       <= '0;
              state     <= ST_LOAD;
            end
          end
          default: begin
            state    <= ST_LOAD;
            idx      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
